// File: rtl/perceptron_seq_learn.sv
// ---------------------------------------------------------------------------
// perceptron_seq_learn
//
// Sequential binary perceptron with optional online training.
//
// A classification walks the weight register file one entry per cycle:
// each feature bit that is set adds its signed weight to an accumulator,
// then the bias is added. No multipliers are needed because the features
// are binary. When training is requested and the decision disagrees with
// the label, a second walk nudges every active weight (and the bias) one
// step toward the label. Each weight saturates at the limits of its
// W_W-bit two's-complement range.
//
// Parameters
//   N_IN   number of binary input features (>= 2)
//   W_W    signed weight / bias width in bits (>= 2)
//   ADDR_W derived: width of the weight/bias address (entry N_IN = bias)
//   ACC_W  derived: signed accumulator width, sized so the worst-case sum
//          of N_IN weights plus the bias cannot overflow
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset; clears state and all weights
//   ena        global enable; when low no register changes
//   start      request a classification (sampled only in IDLE)
//   x          feature vector, captured on an accepted start
//   train      captured with start; enables a weight update on a miss
//   label      target class, captured with start
//   wr_en      weight write strobe (honoured only in IDLE)
//   wr_addr    0..N_IN-1 selects a weight, N_IN the bias, others ignored
//   wr_data    signed value to write
//   busy       high whenever the FSM is not in IDLE
//   done       one-cycle pulse when y / acc_out are freshly valid
//   y          class result: 1 iff the final score is >= 0
//   acc_out    signed final score (two's complement, ACC_W bits)
//   updated    one-cycle pulse on the last edge of a weight update
//   dbg_state  current FSM state, for observation only
//
// Handshake: start is a level sampled on every enabled edge in IDLE; there
// is no ready output, busy low means the next start will be taken. Requests
// and writes presented while busy are dropped, never queued.
// ---------------------------------------------------------------------------
module perceptron_seq_learn #(
    parameter int N_IN   = 8,
    parameter int W_W    = 4,
    localparam int ADDR_W = $clog2(N_IN + 1),
    localparam int ACC_W  = W_W + $clog2(N_IN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic [N_IN-1:0]   x,
    input  logic              train,
    input  logic              label,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W_W-1:0]    wr_data,
    output logic              busy,
    output logic              done,
    output logic              y,
    output logic [ACC_W-1:0]  acc_out,
    output logic              updated,
    output logic [1:0]        dbg_state
);

    // -----------------------------------------------------------------------
    // FSM encoding
    // -----------------------------------------------------------------------
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_DECIDE = 2'd2;
    localparam logic [1:0] S_UPDATE = 2'd3;

    // Index of the final (bias) step of both the ACCUM and UPDATE walks.
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N_IN);

    // Saturation limits and unit step for the weight arithmetic.
    localparam logic signed [W_W-1:0] W_MAX = {1'b0, {(W_W-1){1'b1}}};
    localparam logic signed [W_W-1:0] W_MIN = {1'b1, {(W_W-1){1'b0}}};
    localparam logic signed [W_W-1:0] W_ONE = W_W'(1);

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    logic [1:0]              state_q,   state_d;
    logic [ADDR_W-1:0]       idx_q,     idx_d;
    logic signed [ACC_W-1:0] acc_q,     acc_d;
    logic [N_IN-1:0]         x_q,       x_d;
    logic                    train_q,   train_d;
    logic                    label_q,   label_d;
    logic signed [W_W-1:0]   w_q [N_IN];
    logic signed [W_W-1:0]   w_d [N_IN];
    logic signed [W_W-1:0]   bias_q,    bias_d;
    logic                    y_q,       y_d;
    logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
    logic                    done_q,    done_d;
    logic                    updated_q, updated_d;

    // Operand selected by the walk index: weight idx for 0..N_IN-1, bias at
    // N_IN. The bias is always included, so its "feature bit" is 1.
    logic signed [W_W-1:0]   sel_w;
    logic                    sel_x;
    logic signed [ACC_W-1:0] addend;

    // One saturating step of the perceptron rule: +1 toward class 1,
    // -1 toward class 0, clamped at the range limits.
    function automatic logic signed [W_W-1:0] sat_step(
        input logic signed [W_W-1:0] v,
        input logic                  up
    );
        logic signed [W_W-1:0] r;
        if (up) begin
            r = (v == W_MAX) ? v : v + W_ONE;
        end else begin
            r = (v == W_MIN) ? v : v - W_ONE;
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Operand select (a decoded mux keeps the index width independent of
    // the array depth, so the bias slot at N_IN never indexes past w_q)
    // -----------------------------------------------------------------------
    always_comb begin
        sel_w = bias_q;
        sel_x = 1'b1;
        for (int i = 0; i < N_IN; i++) begin
            if (idx_q == ADDR_W'(i)) begin
                sel_w = w_q[i];
                sel_x = x_q[i];
            end
        end
        // Sign-extend the selected weight to the accumulator width.
        addend = sel_x ? {{(ACC_W-W_W){sel_w[W_W-1]}}, sel_w} : '0;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        x_d       = x_q;
        train_d   = train_q;
        label_d   = label_q;
        bias_d    = bias_q;
        y_d       = y_q;
        acc_out_d = acc_out_q;
        done_d    = 1'b0;
        updated_d = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            w_d[i] = w_q[i];
        end

        case (state_q)
            S_IDLE: begin
                // A write in the same edge as start is safe: the walk only
                // starts reading the register file on the following edge.
                if (wr_en) begin
                    for (int i = 0; i < N_IN; i++) begin
                        if (wr_addr == ADDR_W'(i)) begin
                            w_d[i] = wr_data;
                        end
                    end
                    if (wr_addr == IDX_LAST) begin
                        bias_d = wr_data;
                    end
                end
                if (start) begin
                    x_d     = x;
                    train_d = train;
                    label_d = label;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_ACCUM;
                end
            end

            S_ACCUM: begin
                acc_d = acc_q + addend;
                if (idx_q == IDX_LAST) begin
                    state_d = S_DECIDE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            S_DECIDE: begin
                acc_out_d = acc_q;
                y_d       = ~acc_q[ACC_W-1];
                done_d    = 1'b1;
                // Only a misclassified training sample changes the weights.
                if (train_q && (y_d != label_q)) begin
                    idx_d   = '0;
                    state_d = S_UPDATE;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_UPDATE: begin
                for (int i = 0; i < N_IN; i++) begin
                    if ((idx_q == ADDR_W'(i)) && x_q[i]) begin
                        w_d[i] = sat_step(w_q[i], label_q);
                    end
                end
                if (idx_q == IDX_LAST) begin
                    bias_d    = sat_step(bias_q, label_q);
                    updated_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers. ena gates every update, so the done / updated pulses
    // stretch across disabled cycles until the next enabled edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            x_q       <= '0;
            train_q   <= 1'b0;
            label_q   <= 1'b0;
            bias_q    <= '0;
            y_q       <= 1'b0;
            acc_out_q <= '0;
            done_q    <= 1'b0;
            updated_q <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= '0;
            end
        end else if (ena) begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            train_q   <= train_d;
            label_q   <= label_d;
            bias_q    <= bias_d;
            y_q       <= y_d;
            acc_out_q <= acc_out_d;
            done_q    <= done_d;
            updated_q <= updated_d;
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign y         = y_q;
    assign acc_out   = acc_out_q;
    assign updated   = updated_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_perceptron_seq_learn.sv
// ---------------------------------------------------------------------------
// Testbench for perceptron_seq_learn (N_IN=8, W_W=4).
//
// The reference model treats a classification as one arithmetic event: at
// the accepted start it sums the active weights and the bias, decides the
// class, applies the saturating perceptron rule to its own weight array and
// schedules when done / updated must appear (counted in enabled edges).
// A compare process checks every output against that model on each
// falling clock edge; directed scenarios add hand-computed literals.
// ---------------------------------------------------------------------------
module tb_perceptron_seq_learn;

    localparam int N     = 8;
    localparam int W     = 4;
    localparam int AW    = 4;
    localparam int ACC_W = 8;
    localparam int WMAX  = 7;
    localparam int WMIN  = -8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic          ena = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  x = '0;
    logic          train = 1'b0;
    logic          label = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic          busy, done, y, updated;
    logic [ACC_W-1:0] acc_out;
    logic [1:0]    dbg_state;

    perceptron_seq_learn #(.N_IN(N), .W_W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start),
        .x        (x),
        .train    (train),
        .label    (label),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .y        (y),
        .acc_out  (acc_out),
        .updated  (updated),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mw [N];
    int mb;
    int busy_left, done_left, upd_left;
    int m_s;
    logic exp_busy = 1'b0, exp_done = 1'b0, exp_upd = 1'b0, exp_y = 1'b0;
    logic signed [ACC_W-1:0] exp_acc = '0;
    logic [ACC_W:0] exp_q [$];

    function automatic int clamp(input int v);
        if (v > WMAX) return WMAX;
        if (v < WMIN) return WMIN;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < N; i++) mw[i] = 0;
        mb = 0; busy_left = 0; done_left = 0; upd_left = 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mw[i] = 0;
            mb = 0;
            busy_left = 0; done_left = 0; upd_left = 0;
            exp_busy = 1'b0; exp_done = 1'b0; exp_upd = 1'b0;
            exp_y = 1'b0; exp_acc = '0;
            exp_q.delete();
        end else if (ena) begin
            exp_done = 1'b0;
            exp_upd  = 1'b0;
            if (done_left > 0) begin
                done_left--;
                if (done_left == 0 && exp_q.size() > 0) begin
                    {exp_y, exp_acc} = exp_q.pop_front();
                    exp_done = 1'b1;
                end
            end
            if (upd_left > 0) begin
                upd_left--;
                if (upd_left == 0) exp_upd = 1'b1;
            end
            if (busy_left > 0) begin
                busy_left--;
            end else begin
                if (wr_en) begin
                    for (int i = 0; i < N; i++)
                        if (int'(wr_addr) == i) mw[i] = int'($signed(wr_data));
                    if (int'(wr_addr) == N) mb = int'($signed(wr_data));
                end
                if (start) begin
                    m_s = mb;
                    for (int i = 0; i < N; i++) if (x[i]) m_s += mw[i];
                    exp_q.push_back({(m_s >= 0), ACC_W'(m_s)});
                    done_left = N + 2;
                    if (train && ((m_s >= 0) != label)) begin
                        for (int i = 0; i < N; i++)
                            if (x[i]) mw[i] = clamp(mw[i] + (label ? 1 : -1));
                        mb = clamp(mb + (label ? 1 : -1));
                        busy_left = 2 * N + 3;
                        upd_left  = 2 * N + 3;
                    end else begin
                        busy_left = N + 2;
                    end
                end
            end
            exp_busy = (busy_left > 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",    int'(busy),    int'(exp_busy));
            check("done",    int'(done),    int'(exp_done));
            check("updated", int'(updated), int'(exp_upd));
            check("y",       int'(y),       int'(exp_y));
            check("acc_out", int'($signed(acc_out)), int'(exp_acc));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
    endtask

    task automatic do_write(input int addr, input int data);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(addr); wr_data = W'(data);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Runs one classification; gap > 0 drops ena for gap cycles mid-ACCUM.
    task automatic run_class(input logic [N-1:0] xv, input logic tr, input logic lb,
                             input int gap, output int lat, output int acc_v,
                             output int y_v, output int busy_next, output int upd_lat);
        int c0, cd;
        lat = -1; upd_lat = -1; acc_v = 0; y_v = 0; busy_next = 1; cd = 0;
        @(negedge clk);
        x = xv; train = tr; label = lb; start = 1'b1;
        @(negedge clk);
        start = 1'b0; c0 = cyc;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                lat = cyc - c0; cd = cyc;
                acc_v = int'($signed(acc_out)); y_v = int'(y);
                break;
            end
            if (gap > 0 && i == 2) ena = 1'b0;
            if (gap > 0 && i == 2 + gap) ena = 1'b1;
            @(negedge clk);
        end
        ena = 1'b1;
        @(negedge clk);
        busy_next = int'(busy);
        if (updated) upd_lat = cyc - cd;
        for (int j = 0; j < 40 && busy; j++) begin
            @(negedge clk);
            if (updated && upd_lat < 0) upd_lat = cyc - cd;
        end
    endtask

    // ---------------- stimulus ----------------
    int lat, acc_v, y_v, bn, ul;

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Reset values
        check("rst_busy",    int'(busy),    0);
        check("rst_done",    int'(done),    0);
        check("rst_y",       int'(y),       0);
        check("rst_updated", int'(updated), 0);
        check("rst_acc",     int'($signed(acc_out)), 0);

        // Zero weights, all features on
        run_class(8'hFF, 1'b0, 1'b0, 0, lat, acc_v, y_v, bn, ul);
        check("t1_latency", lat, 10);
        check("t1_acc", acc_v, 0);
        check("t1_y", y_v, 1);
        check("t1_busy_after", bn, 0);

        // w0=-3, bias=+2, inference only
        do_reset();
        do_write(0, -3);
        do_write(8, 2);
        run_class(8'h01, 1'b0, 1'b0, 0, lat, acc_v, y_v, bn, ul);
        check("t2_acc", acc_v, -1);
        check("t2_y", y_v, 0);
        check("t2_no_update", ul, -1);

        // Same with training toward class 1
        do_reset();
        do_write(0, -3);
        do_write(8, 2);
        run_class(8'h01, 1'b1, 1'b1, 0, lat, acc_v, y_v, bn, ul);
        check("t3_acc", acc_v, -1);
        check("t3_y", y_v, 0);
        check("t3_upd_latency", ul, 9);
        run_class(8'h01, 1'b0, 1'b0, 0, lat, acc_v, y_v, bn, ul);
        check("t3_rerun_acc", acc_v, 1);
        check("t3_rerun_y", y_v, 1);
        run_class(8'hFE, 1'b0, 1'b0, 0, lat, acc_v, y_v, bn, ul);
        check("t3_others_acc", acc_v, 3);

        // Saturation at both ends
        do_reset();
        do_write(0, 7);
        do_write(8, -8);
        run_class(8'h01, 1'b1, 1'b1, 0, lat, acc_v, y_v, bn, ul);
        check("t4_y", y_v, 0);
        check("t4_upd_latency", ul, 9);
        run_class(8'h01, 1'b0, 1'b0, 0, lat, acc_v, y_v, bn, ul);
        check("t4_w0_plus_bias", acc_v, 0);
        run_class(8'h00, 1'b0, 1'b0, 0, lat, acc_v, y_v, bn, ul);
        check("t4_bias", acc_v, -7);

        // Start and write while busy are dropped
        do_reset();
        do_write(3, 2);
        @(negedge clk);
        x = 8'h00; train = 1'b0; label = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_busy_mid", int'(busy), 1);
        start = 1'b1; x = 8'hFF; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 4'hB;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_idle", int'(busy), 0);
        check("t5_acc", int'($signed(acc_out)), 0);
        run_class(8'h08, 1'b0, 1'b0, 0, lat, acc_v, y_v, bn, ul);
        check("t5_w3_readout", acc_v, 2);

        // Reset in the middle of ACCUM
        do_reset();
        do_write(0, 3);
        run_class(8'h01, 1'b0, 1'b0, 0, lat, acc_v, y_v, bn, ul);
        check("t6_pre_acc", acc_v, 3);
        check("t6_pre_y", y_v, 1);
        @(negedge clk);
        x = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_busy_before", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_y", int'(y), 0);
        check("t6_rst_acc", int'($signed(acc_out)), 0);
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b1;
        run_class(8'hFF, 1'b0, 1'b0, 0, lat, acc_v, y_v, bn, ul);
        check("t6_weights_cleared", acc_v, 0);

        // ena held low for 5 cycles mid-ACCUM
        do_reset();
        do_write(0, -3);
        do_write(8, 2);
        run_class(8'h01, 1'b0, 1'b0, 5, lat, acc_v, y_v, bn, ul);
        check("t7_latency", lat, 15);
        check("t7_acc", acc_v, -1);
        check("t7_y", y_v, 0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            ena     = ($urandom_range(0, 9) != 0);
            start   = ($urandom_range(0, 5) == 0);
            x       = N'($urandom);
            train   = 1'($urandom);
            label   = 1'($urandom);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = AW'($urandom_range(0, 15));
            wr_data = W'($urandom);
        end
        @(negedge clk);
        ena = 1'b1; start = 1'b0; wr_en = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/perceptron_seq_learn.md
Name: perceptron_seq_learn

Overview:
- Parametrised sequential successor to the fixed combinational perceptron classifier.
- Scores N_IN binary features against a register file of signed weights plus a bias, using one multiply-free accumulate step per cycle.
- Optional online training applies the perceptron rule, w += ±x, with saturation.
- Sits behind the TinyTapeout top wrapper. Features and control come from ui_in/uio_in; y/done/busy drive uo_out.

Parameters:
- N_IN, 8, number of binary input features (≥2).
- W_W, 4, signed weight/bias width in bits (≥2).
- ACC_W, derived localparam = W_W + clog2(N_IN+1), signed accumulator width; cannot overflow.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  global enable; low freezes all state
- start  input  1  request classification; sampled only in IDLE
- x  input  N_IN  feature vector; captured on accepted start
- train  input  1  captured with start; enables weight update on misclassify
- label  input  1  target class; captured with start
- wr_en  input  1  weight write strobe; honoured only in IDLE
- wr_addr  input  clog2(N_IN+1)  0..N_IN-1 = weights, N_IN = bias; larger values ignored
- wr_data  input  W_W  signed write value
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse when y/acc_out become valid
- y  output  1  class result: 1 iff acc ≥ 0
- acc_out  output  ACC_W  signed final score
- updated  output  1  one-cycle pulse at end of a weight update

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; all weights and bias = 0.
  - busy=0, done=0, y=0, updated=0, acc_out=0, idx=0.
  - Reset mid-operation aborts immediately. Partial updates are discarded only to the extent that weights are cleared.
- ena=0: no register changes (apart from reset). Pulses already high hold until the next enabled edge.
- States: IDLE → ACCUM → DECIDE → (UPDATE) → IDLE.
- IDLE:
  - start=1 at edge k: capture x/train/label, acc←0, idx←0, go to ACCUM.
  - wr_en at the same edge also writes. Because accumulation reads from edge k+1 onward, the new value is used.
- ACCUM, edges k+1..k+N_IN+1:
  - idx 0..N_IN-1 adds w[idx] if x[idx]=1; idx=N_IN adds bias.
  - All operands are sign-extended to ACC_W.
  - After idx=N_IN, go to DECIDE.
- DECIDE, edge k+N_IN+2:
  - Register acc_out←acc and y←(acc≥0); pulse done for exactly that cycle.
  - Latency from the start edge to done high is N_IN+2 cycles.
  - If train=1 and y≠label, go to UPDATE; otherwise go to IDLE (busy low the next cycle).
- UPDATE, N_IN+1 edges:
  - idx 0..N_IN-1: if x[idx]=1, w[idx] ← sat(w[idx] + (label ? +1 : −1)).
  - idx=N_IN: bias gets the same ± step unconditionally.
  - Saturation limits are +2^(W_W−1)−1 and −2^(W_W−1).
  - On the last edge, pulse updated and go to IDLE.
- While busy: start and wr_en are ignored, and writes are dropped (not queued).
- y and acc_out hold their value until the next DECIDE.

Test Plan:
- Zero weights after reset, N_IN=8, x=0xFF, start → done exactly 10 cycles later, acc_out=0, y=1, busy low on the next cycle.
- Write w0=−3 and bias=+2, x=0x01, train=0 → acc_out=−1, y=0, no UPDATE, updated stays 0.
- Same setup with train=1, label=1 → done, then updated 9 cycles later. Weights become w0=−2, bias=3, all others 0. A re-run gives acc_out=1, y=1.
- Saturation: w0=+7, bias=−8, x=0x01, train=1, label=1 → y=0. After the update, w0 stays +7 and bias=−7.
- Control blocking: start pulse and a wr_en to addr 3 while busy → both ignored. A later read-out via classification with x=0x08 shows w3 unchanged.
- Robustness:
  - rst_n low mid-ACCUM → busy=0, y=0 and all weights 0 asynchronously.
  - ena held low for 5 cycles mid-ACCUM → done delayed by exactly 5 cycles with an unchanged result.
